pc_redirect_ctrl: RTL
=====================

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the address width of ex_target and redir_addr.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of each statistics counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 ex_valid  input  1  EX stage holds a valid instruction.
REQ-006 ex_br  input  1  EX instruction is a conditional branch; this is the branch-enable input of the jump decision unit.
REQ-007 ex_jmp  input  1  EX instruction is JAL/JALR, i.e. unconditional.
REQ-008 pcs  input  1  branch-taken decision from the jump decision unit, evaluated from funct3 and the ZERO/SLT/SLTU flags.
REQ-009 ex_target  input  XLEN  resolved branch/jump target.
REQ-010 kill  input  1  trap/exception abort of any pending redirect.
REQ-011 cnt_clr  input  1  synchronous clear of both counters.
REQ-012 redir_ready  input  1  fetch unit accepts the redirect.
REQ-013 redir_valid  output  1  redirect request to the fetch unit.
REQ-014 redir_addr  output  XLEN  redirect target.
REQ-015 flush_ifid, flush_idex  output  1 each  pipeline-register flush.
REQ-016 stall_if  output  1  freeze PC and the IF/ID register.
REQ-017 br_cnt, taken_cnt  output  CNT_W each  resolved-branch count and taken-branch count.

Function
REQ-018 The block SHALL define take = ex_valid & (ex_jmp | (ex_br & pcs)); ex_jmp has priority, so ex_br=1 with ex_jmp=1 is treated as a jump only.
REQ-019 The FSM SHALL have states IDLE, REDIR and DRAIN; all outputs SHALL be registered or decoded from state and registers only, never combinationally from inputs.
REQ-020 In IDLE with take=1 at an edge, the FSM SHALL move to REDIR and latch redir_addr <= ex_target at that edge.
REQ-021 In IDLE with take=0, the FSM SHALL stay in IDLE.
REQ-022 In REDIR the block SHALL drive redir_valid=1, flush_ifid=1, flush_idex=1 and stall_if=1.
REQ-023 While in REDIR, redir_valid and redir_addr SHALL remain stable until the handshake completes.
REQ-024 In REDIR with redir_valid & redir_ready at an edge, the FSM SHALL move to DRAIN; the handshake therefore completes in the first REDIR cycle at the earliest, giving 1-cycle latency from the take edge to redir_valid.
REQ-025 DRAIN SHALL last exactly one cycle with flush_ifid=1, flush_idex=0, stall_if=0, redir_valid=0, then return to IDLE.
REQ-026 In REDIR or DRAIN, take SHALL be ignored, since wrong-path instructions are flushed: no new redirect and no counter update.
REQ-027 In REDIR, kill=1 SHALL force IDLE at the next edge regardless of redir_ready; this is the only case where redir_valid drops without a handshake.
REQ-028 kill=1 in IDLE SHALL suppress a simultaneous take; kill=1 in DRAIN SHALL have no effect.
REQ-029 In IDLE with ex_valid & ex_br & ~ex_jmp & ~kill, br_cnt SHALL increment by 1, and taken_cnt SHALL also increment by 1 if pcs=1.
REQ-030 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-031 cnt_clr=1 SHALL set both counters to 0 at the next edge and SHALL win over a simultaneous increment.
REQ-032 In IDLE all of redir_valid, flush_ifid, flush_idex and stall_if SHALL be 0.

Reset
REQ-033 rst_n=0 SHALL immediately, without waiting for a clock edge, force state IDLE, redir_valid=0, redir_addr=0, flush_ifid=0, flush_idex=0, stall_if=0, br_cnt=0 and taken_cnt=0.
REQ-034 Reset asserted mid-redirect SHALL abandon the redirect; after deassertion the block SHALL start in IDLE.
REQ-035 The first edge after rst_n rises SHALL be processed normally.

Verification
REQ-036 Taken BEQ: ex_valid=1, ex_br=1, pcs=1, ex_target=0x0000_0100, redir_ready=1 -> next cycle redir_valid=1, redir_addr=0x100 and both flushes=1; following cycle DRAIN with flush_ifid=1 only; then IDLE; br_cnt=1, taken_cnt=1.
REQ-037 Not-taken branch: ex_br=1, pcs=0 -> no redirect, all control outputs 0, br_cnt=1, taken_cnt=0.
REQ-038 Backpressure: JAL with target 0x200, redir_ready=0 for 3 cycles -> redir_valid=1 with addr 0x200 held stable for 4 cycles, stall_if=1 throughout, a take presented during the wait is ignored, counters unchanged.
REQ-039 kill in REDIR with redir_ready=0 -> IDLE next cycle, redir_valid=0, no DRAIN cycle.
REQ-040 Saturation and clear: with CNT_W=4, 17 taken branches -> br_cnt=15 and taken_cnt=15; then cnt_clr=1 together with a branch -> both counters=0.
REQ-041 Async reset: rst_n pulsed low mid-REDIR between clock edges -> all outputs 0 immediately; a taken branch after release redirects normally.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_redirect_ctrl
// Purpose  : Turns an EX-stage branch/jump decision into a fetch redirect
//            request with ready/valid handshake, flushes the wrong-path
//            pipeline registers and keeps saturating branch statistics.
// Revision : 1.0 - initial release
// ============================================================================
module pc_redirect_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_br,
  input  logic             ex_jmp,
  input  logic             pcs,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             kill,
  input  logic             cnt_clr,
  input  logic             redir_ready,
  output logic             redir_valid,
  output logic [XLEN-1:0]  redir_addr,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             stall_if,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REDIR = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       take;
  logic       start_redir;
  logic       br_resolve;

  // A jump always redirects; a conditional branch only when the decision unit says taken.
  assign take        = ex_valid & (ex_jmp | (ex_br & pcs));
  // Only IDLE accepts a new redirect; kill in the same cycle suppresses it.
  assign start_redir = (state == ST_IDLE) & take & ~kill;
  // A conditional branch (not a jump) resolving while nothing is in flight.
  assign br_resolve  = (state == ST_IDLE) & ex_valid & ex_br & ~ex_jmp & ~kill;

  // State register; reset drops any in-flight redirect immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; redir_valid is 1 throughout REDIR so ready alone completes the handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_redir) begin
          state_nxt = ST_REDIR;
        end
      end
      ST_REDIR: begin
        if (kill) begin
          state_nxt = ST_IDLE;
        end else if (redir_ready) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Control outputs decoded purely from state, so they never glitch on inputs.
  always_comb begin
    redir_valid = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    stall_if    = 1'b0;
    case (state)
      ST_REDIR: begin
        redir_valid = 1'b1;
        flush_ifid  = 1'b1;
        flush_idex  = 1'b1;
        stall_if    = 1'b1;
      end
      ST_DRAIN: begin
        flush_ifid  = 1'b1;
      end
      default: begin
        redir_valid = 1'b0;
      end
    endcase
  end

  // Target is captured only on the IDLE->REDIR edge, so it holds steady while waiting for ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redir_addr <= '0;
    end else if (start_redir) begin
      redir_addr <= ex_target;
    end
  end

  // Saturating branch statistics; clear takes precedence over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else if (cnt_clr) begin
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else if (br_resolve) begin
      if (br_cnt != CNT_MAX) begin
        br_cnt <= br_cnt + 1'b1;
      end
      if (pcs && (taken_cnt != CNT_MAX)) begin
        taken_cnt <= taken_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
